tcm3_gf2_mul_sequencer: RTL and testbench

//  Area-lean 3-way split GF(2)[x] (carry-less) polynomial multiplier for the large-integer library.

---
 rtl/tcm3_gf2_mul_sequencer_pkg.sv | 11 +
 rtl/tcm3_gf2_mul_sequencer_mac.sv | 15 +
 rtl/tcm3_gf2_mul_sequencer.sv | 106 ++++++++++
 tb/tb_tcm3_gf2_mul_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tcm3_gf2_mul_sequencer_pkg.sv
// tcm3_pkg: shared FSM encoding, sub-product pair order and limb-width helper for the GF(2) multiplier sequencer
package tcm3_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  // Pair k selects (i,j) = (PAIR_I[k], PAIR_J[k]); element 0 is the rightmost entry.
  localparam logic [8:0][1:0] PAIR_I = {2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
  localparam logic [8:0][1:0] PAIR_J = {2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
  localparam logic [3:0] LAST_PAIR = 4'd8;
  function automatic int lw(input int w);
    return (w + 2) / 3;
  endfunction
endpackage

// File: rtl/tcm3_gf2_mul_sequencer_mac.sv
// gf2_serial_mac: one shift-XOR step of a carry-less multiply
//  acc_i  running product
//  term_i b limb already shifted to its final bit position
//  bit_i  current multiplier bit of the a limb
//  acc_o  next running product
module gf2_serial_mac #(
  parameter int W = 342
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] term_i,
  input  logic         bit_i,
  output logic [W-1:0] acc_o
);
  assign acc_o = bit_i ? acc_i ^ term_i : acc_i;
endmodule

// File: rtl/tcm3_gf2_mul_sequencer.sv
// tcm3_gf2_mul_sequencer: bit-serial 3-way split carry-less multiplier, nine limb products through one MAC
//  clk, rst             clock, asynchronous active-high reset
//  in_valid/in_ready    operand handshake; a, b operands
//  out_valid/out_ready  result handshake; c registered product
//  busy                 high in RUN or DONE
//  phase                current pair index while in RUN, else 0
module tcm3_gf2_mul_sequencer
  import tcm3_pkg::*;
#(
  parameter int A_W = 192,
  parameter int B_W = 150,
  localparam int L = lw(A_W),
  localparam int C_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [C_W-1:0] c,
  output logic           busy,
  output logic [3:0]     phase
);
  localparam int BIT_W = $clog2(L);
  state_t state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [C_W-1:0] acc_q, acc_d, c_q, c_d, acc_mac, term;
  logic [L-1:0] a_limb, b_limb;
  logic [1:0] li, lj;
  logic last_bit;
  // Shifting the operand down before truncating makes bits above A_W/B_W read as zero.
  always_comb begin
    li = PAIR_I[k_q];
    lj = PAIR_J[k_q];
    a_limb = L'(a_q >> (L * li));
    b_limb = L'(b_q >> (L * lj));
    term = C_W'(b_limb) << (L * (li + lj) + bit_q);
    last_bit = bit_q == BIT_W'(L - 1);
  end
  gf2_serial_mac #(.W(C_W)) u_mac (
    .acc_i (acc_q),
    .term_i(term),
    .bit_i (a_limb[bit_q]),
    .acc_o (acc_mac)
  );
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    bit_d = bit_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    c_d = c_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        acc_d = '0;
        k_d = '0;
        bit_d = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = acc_mac;
        bit_d = last_bit ? '0 : bit_q + 1'b1;
        k_d = last_bit ? k_q + 4'd1 : k_q;
        if (last_bit && k_q == LAST_PAIR) begin
          c_d = acc_mac;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      bit_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      c_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      bit_q <= bit_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      c_q <= c_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign phase = state_q == RUN ? k_q : 4'd0;
  assign c = c_q;
endmodule

// File: tb/tb_tcm3_gf2_mul_sequencer.sv
// tb_tcm3_gf2_mul_sequencer: scoreboard bench with directed and random carry-less products
module tb_tcm3_gf2_mul_sequencer;
  localparam int A_W = 192;
  localparam int B_W = 150;
  localparam int L = 64;
  localparam int C_W = 342;
  localparam int LAT = 9 * L + 1;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic in_ready, out_valid, out_ready, busy;
  logic man_rdy = 1;
  logic rnd_rdy = 1;
  logic rnd_stall = 0;
  logic [A_W-1:0] a = '0;
  logic [B_W-1:0] b = '0;
  logic [C_W-1:0] c;
  logic [3:0] phase;
  int checks = 0;
  int errors = 0;
  int cyc = -1;
  logic [C_W-1:0] sb[$];
  assign out_ready = rnd_stall ? rnd_rdy : man_rdy;
  always #5 clk = ~clk;
  tcm3_gf2_mul_sequencer #(.A_W(A_W), .B_W(B_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .busy(busy), .phase(phase)
  );
  task automatic chk(input string nm, input logic [C_W-1:0] act, input logic [C_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  function automatic logic [C_W-1:0] clmul(input logic [A_W-1:0] x, input logic [B_W-1:0] y);
    logic [C_W-1:0] r = '0;
    for (int i = 0; i < A_W; i++) if (x[i]) r ^= C_W'(y) << i;
    return r;
  endfunction
  task automatic issue(input logic [A_W-1:0] ta, input logic [B_W-1:0] tbv, input logic [C_W-1:0] exp);
    int n = 0;
    @(posedge clk);
    #1;
    a = ta;
    b = tbv;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", C_W'(in_ready), C_W'(1));
    else begin
      @(posedge clk);
      sb.push_back(exp);
    end
    #1;
    in_valid = 0;
    a = {6{$urandom()}};
    b = B_W'({5{$urandom()}});
  endtask
  always @(posedge clk) begin
    #1;
    rnd_rdy = $urandom_range(0, 3) != 0;
  end
  always @(negedge clk) begin
    if (rst) cyc = -1;
    else begin
      if (cyc >= 1 && cyc < LAT) begin
        chk("run_status", C_W'({out_valid, in_ready, busy, phase}), C_W'({3'b001, 4'((cyc - 1) / L)}));
        cyc++;
      end else if (cyc == LAT) begin
        chk("done_status", C_W'({out_valid, in_ready, busy, phase}), C_W'(7'b1010000));
        cyc = -1;
      end
      if (in_valid && in_ready) cyc = 1;
    end
  end
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got=%h want=none", c);
      end else chk("c", c, sb.pop_front());
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [A_W-1:0] ra;
    logic [B_W-1:0] rb;
    int n;
    #12;
    chk("reset_status", C_W'({out_valid, in_ready, busy, phase}), C_W'(7'b0100000));
    chk("reset_c", c, '0);
    @(negedge clk);
    rst = 0;
    issue(A_W'(1), B_W'(1), C_W'(1));
    issue(A_W'(3), B_W'(3), C_W'(5));
    issue(A_W'(1) << 191, B_W'(1) << 149, C_W'(1) << 340);
    issue('1, '0, '0);
    issue('0, '1, '0);
    issue(A_W'(7), B_W'(5), C_W'(27));
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    man_rdy = 0;
    issue((A_W'(1) << 64) | A_W'(1), (B_W'(1) << 64) | B_W'(1), (C_W'(1) << 128) | C_W'(1));
    n = 0;
    while (!out_valid && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("stall_wait", C_W'(out_valid), C_W'(1));
    fork
      begin
        repeat (20) begin
          @(negedge clk);
          chk("stall_status", C_W'({out_valid, in_ready, busy}), C_W'(3'b101));
          chk("stall_c", c, (C_W'(1) << 128) | C_W'(1));
        end
        @(posedge clk);
        #1;
        man_rdy = 1;
        @(negedge clk);
        @(negedge clk);
        chk("release_idle", C_W'({out_valid, in_ready, busy}), C_W'(3'b010));
        @(negedge clk);
        chk("release_accept", C_W'({out_valid, in_ready, busy}), C_W'(3'b001));
      end
      issue(A_W'(1) << 128, B_W'(1) << 128, C_W'(1) << 256);
    join
    issue('1, '1, clmul('1, '1));
    repeat (299) @(posedge clk);
    #2;
    chk("pre_rst_phase", C_W'(phase), C_W'(4));
    rst = 1;
    #1;
    chk("async_rst_status", C_W'({out_valid, in_ready, busy, phase}), C_W'(7'b0100000));
    chk("async_rst_c", c, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    issue(A_W'(5), B_W'(7), C_W'(27));
    rnd_stall = 1;
    for (int i = 0; i < 40; i++) begin
      ra = {6{$urandom()}};
      rb = B_W'({5{$urandom()}});
      if (i % 8 == 3) ra[127:64] = '0;
      issue(ra, rb, clmul(ra, rb));
    end
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", C_W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
